// File: rtl/axis_burst_packetizer_pkg.sv
// Shared definitions for the AXI-Stream burst packetizer: FSM states and sizing helpers.
package axis_burst_packetizer_pkg;

  // Burst controller states: wait for enable, wait for enough data, move one burst.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int BEATS_W = 16;
  localparam int CNT_W   = 32;

  // Timeout counter width; keeps at least one bit when the timeout is disabled.
  function automatic int tmo_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/axis_burst_packetizer_out_reg.sv
// One-entry registered AXI-Stream output stage. The upstream logic only loads it
// when it is empty or draining, so a held beat is never overwritten.
module axis_burst_packetizer_out_reg #(
  parameter int TDATA_WIDTH = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [TDATA_WIDTH-1:0] data_i,
  input  logic                   last_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [TDATA_WIDTH-1:0] data_o,
  output logic                   last_o
);

  logic                   valid_q, valid_d;
  logic [TDATA_WIDTH-1:0] data_q, data_d;
  logic                   last_q, last_d;

  // Load a new beat, or retire the held one once the consumer accepts it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register; reset drops any held beat and clears the visible data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/axis_burst_packetizer.sv
// Drains an AXI-Stream FIFO in fixed-length bursts and tags the final beat with TLAST.
// A burst only starts once the FIFO holds a full burst; leftovers go out as a short
// burst after an idle timeout or an explicit flush.
module axis_burst_packetizer
  import axis_burst_packetizer_pkg::*;
#(
  parameter int TDATA_WIDTH    = 128,
  parameter int BURST_LEN      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  input  logic [31:0]            fifo_count,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic                   M_AXIS_TLAST,
  output logic                   busy,
  output logic [31:0]            burst_count,
  output logic [31:0]            short_burst_count
);

  localparam int                 TMO_W       = tmo_width(TIMEOUT_CYCLES);
  localparam bit                 TMO_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]        BURST_LEN_C = 32'(BURST_LEN);
  localparam logic [BEATS_W-1:0] BURST_LEN_B = BEATS_W'(BURST_LEN);

  state_t             state_q, state_d;
  logic [BEATS_W-1:0] beats_left_q, beats_left_d;
  logic               is_short_q, is_short_d;
  logic               flush_pend_q, flush_pend_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]   short_cnt_q, short_cnt_d;

  logic m_valid, m_last, s_ready, in_hs, last_hs;
  logic full_ok, partial, short_ok;

  // Handshake and start conditions derived from the current state and FIFO level.
  always_comb begin
    s_ready  = (state_q == STREAM) && (beats_left_q != '0) && (!m_valid || M_AXIS_TREADY);
    in_hs    = s_ready && S_AXIS_TVALID;
    last_hs  = m_valid && M_AXIS_TREADY && m_last;
    full_ok  = (fifo_count >= BURST_LEN_C);
    partial  = (fifo_count != 32'd0) && !full_ok;
    short_ok = (fifo_count != 32'd0) &&
               (flush_pend_q || (TMO_EN && (tmo_cnt_q == TMO_LAST)));
  end

  // Burst FSM next state, beat budget, flush/timeout bookkeeping and counters.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    is_short_d   = is_short_q;
    flush_pend_d = flush_pend_q | flush;
    tmo_cnt_d    = '0;
    burst_cnt_d  = burst_cnt_q + (last_hs ? 32'd1 : 32'd0);
    short_cnt_d  = short_cnt_q + ((last_hs && is_short_q) ? 32'd1 : 32'd0);
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = ARM;
      end
      ARM: begin
        if (full_ok) begin
          // A full burst wins over a pending flush; the flush stays pending.
          state_d      = STREAM;
          beats_left_d = BURST_LEN_B;
          is_short_d   = 1'b0;
        end else if (short_ok) begin
          state_d      = STREAM;
          beats_left_d = fifo_count[BEATS_W-1:0];
          is_short_d   = 1'b1;
          flush_pend_d = 1'b0;
        end else begin
          // Nothing left to flush once the FIFO is empty.
          if (fifo_count == 32'd0) flush_pend_d = flush;
          if (partial && TMO_EN) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (!enable) state_d = IDLE;
        end
      end
      STREAM: begin
        if (in_hs) beats_left_d = beats_left_q - BEATS_W'(1);
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; a reset abandons any partial burst without emitting TLAST.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      is_short_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      tmo_cnt_q    <= '0;
      burst_cnt_q  <= '0;
      short_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      is_short_q   <= is_short_d;
      flush_pend_q <= flush_pend_d;
      tmo_cnt_q    <= tmo_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      short_cnt_q  <= short_cnt_d;
    end
  end

  axis_burst_packetizer_out_reg #(
    .TDATA_WIDTH(TDATA_WIDTH)
  ) u_out_reg (
    .clk_i  (aclk),
    .rst_i  (reset),
    .load_i (in_hs),
    .data_i (S_AXIS_TDATA),
    .last_i (beats_left_q == BEATS_W'(1)),
    .ready_i(M_AXIS_TREADY),
    .valid_o(m_valid),
    .data_o (M_AXIS_TDATA),
    .last_o (m_last)
  );

  assign S_AXIS_TREADY     = s_ready;
  assign M_AXIS_TVALID     = m_valid;
  assign M_AXIS_TLAST      = m_last;
  assign busy              = (state_q != IDLE);
  assign burst_count       = burst_cnt_q;
  assign short_burst_count = short_cnt_q;

endmodule

// File: tb/tb_axis_burst_packetizer.sv
// Bench for axis_burst_packetizer: FIFO model upstream, packet scoreboard downstream.
module tb_axis_burst_packetizer;

  localparam int W   = 128;
  localparam int BL  = 4;
  localparam int TMO = 8;

  logic          aclk = 1'b0;
  logic          reset, enable, flush;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid, s_tready;
  logic [31:0]   fifo_count;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid, m_tready, m_tlast, busy;
  logic [31:0]   burst_count, short_count;

  always #5 aclk = ~aclk;

  axis_burst_packetizer #(
    .TDATA_WIDTH(W), .BURST_LEN(BL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .reset(reset), .enable(enable), .flush(flush),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .fifo_count(fifo_count),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .M_AXIS_TLAST(m_tlast), .busy(busy), .burst_count(burst_count),
    .short_burst_count(short_count)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] got_data[$];
  logic         got_last[$];
  int           got_cyc[$];
  bit           hold_pend = 1'b0;
  logic [W-1:0] hold_data;
  logic         hold_last;

  typedef struct {
    int          nbeats;
    bit          do_flush;
    bit          toggle;
    int          exp_bursts;
    int          exp_short;
    logic [15:0] last_mask;
  } vec_t;

  vec_t vecs[5];

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    s_tvalid   = (fifo_q.size() != 0);
    s_tdata    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    fifo_count = 32'(fifo_q.size());
  endtask

  task automatic push_seq(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(W'(base + i));
    drive_fifo();
  endtask

  // One clock: snapshot handshakes at the falling edge, apply them after the rising edge.
  task automatic step();
    bit           s_hs, m_hs;
    logic [W-1:0] md;
    logic         ml;
    @(negedge aclk);
    if (hold_pend) begin
      check_int("hold_valid", int'(m_tvalid), 1);
      check_int("hold_stable", int'((m_tdata === hold_data) && (m_tlast === hold_last)), 1);
    end
    s_hs      = !reset && s_tvalid && s_tready;
    m_hs      = !reset && m_tvalid && m_tready;
    md        = m_tdata;
    ml        = m_tlast;
    hold_pend = !reset && m_tvalid && !m_tready;
    hold_data = md;
    hold_last = ml;
    @(posedge aclk);
    #1;
    cyc++;
    if (s_hs) void'(fifo_q.pop_front());
    if (m_hs) begin
      got_data.push_back(md);
      got_last.push_back(ml);
      got_cyc.push_back(cyc);
    end
    drive_fifo();
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    flush    = 1'b0;
    m_tready = 1'b1;
    fifo_q.delete();
    drive_fifo();
    repeat (2) step();
    reset     = 1'b0;
    hold_pend = 1'b0;
    clear_got();
  endtask

  // Run until n output beats have been seen, with a bounded cycle budget.
  task automatic run_until(input int n, input int max_cyc, input bit toggle, input string name);
    int k = 0;
    while (got_data.size() < n && k < max_cyc) begin
      if (toggle) m_tready = (k % 2 == 0);
      step();
      k++;
    end
    m_tready = 1'b1;
    check_int({name, "_beats"}, got_data.size(), n);
  endtask

  function automatic int last_mask();
    int m = 0;
    for (int i = 0; i < got_last.size() && i < 31; i++) if (got_last[i]) m |= (1 << i);
    return m;
  endfunction

  function automatic int data_errs(input int base);
    int e = 0;
    for (int i = 0; i < got_data.size(); i++) if (got_data[i] !== W'(base + i)) e++;
    return e;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sent[$];
    logic [W-1:0] d;
    int           bad, len, pk, sh, k;

    vecs[0] = '{8, 1'b0, 1'b0, 2, 0, 16'h0088};
    vecs[1] = '{3, 1'b0, 1'b0, 1, 1, 16'h0004};
    vecs[2] = '{2, 1'b1, 1'b0, 1, 1, 16'h0002};
    vecs[3] = '{8, 1'b0, 1'b1, 2, 0, 16'h0088};
    vecs[4] = '{6, 1'b0, 1'b0, 2, 1, 16'h0028};

    // Reset state
    do_reset();
    check_int("rst_m_tvalid", int'(m_tvalid), 0);
    check_data("rst_m_tdata", m_tdata, '0);
    check_int("rst_m_tlast", int'(m_tlast), 0);
    check_int("rst_s_tready", int'(s_tready), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_burst_count", int'(burst_count), 0);
    check_int("rst_short_count", int'(short_count), 0);

    // Table-driven packet scenarios
    for (int v = 0; v < 5; v++) begin
      do_reset();
      push_seq(vecs[v].nbeats, 16 * v + 1);
      enable = 1'b1;
      flush  = vecs[v].do_flush;
      step();
      flush = 1'b0;
      run_until(vecs[v].nbeats, 200, vecs[v].toggle, $sformatf("vec%0d", v));
      repeat (2) step();
      check_int($sformatf("vec%0d_data", v), data_errs(16 * v + 1), 0);
      check_int($sformatf("vec%0d_tlast", v), last_mask(), int'(vecs[v].last_mask));
      check_int($sformatf("vec%0d_bursts", v), int'(burst_count), vecs[v].exp_bursts);
      check_int($sformatf("vec%0d_short", v), int'(short_count), vecs[v].exp_short);
      check_int($sformatf("vec%0d_fifo_empty", v), fifo_q.size(), 0);
    end

    // Back-to-back beats inside each full burst
    do_reset();
    push_seq(8, 'h40);
    enable = 1'b1;
    run_until(8, 100, 1'b0, "gaps");
    bad = 0;
    for (int i = 0; i + 1 < got_cyc.size(); i++)
      if (!got_last[i] && got_cyc[i + 1] != got_cyc[i] + 1) bad++;
    check_int("no_gaps", bad, 0);

    // Partial data waits exactly TMO cycles in ARM before the short burst
    do_reset();
    push_seq(3, 'h50);
    enable = 1'b1;
    k = 0;
    step();
    while (!s_tready && k < 50) begin
      if (busy) k++;
      step();
    end
    check_int("arm_cycles", k, TMO);
    run_until(3, 50, 1'b0, "tmo");
    check_int("tmo_short", int'(short_count), 1);

    // Flush starts a short burst promptly and leaves nothing pending
    do_reset();
    push_seq(2, 'h60);
    enable = 1'b1;
    flush  = 1'b1;
    step();
    flush = 1'b0;
    k = 1;
    while (!s_tready && k < 20) begin
      step();
      k++;
    end
    check_int("flush_start_le2", int'(k <= 2), 1);
    run_until(2, 50, 1'b0, "flush");
    repeat (30) step();
    check_int("flush_bursts", int'(burst_count), 1);
    check_int("flush_short", int'(short_count), 1);

    // Enable dropped mid-burst: current burst completes, rest of FIFO untouched
    do_reset();
    push_seq(8, 'h70);
    enable = 1'b1;
    run_until(2, 50, 1'b0, "endrop_pre");
    enable = 1'b0;
    run_until(4, 50, 1'b0, "endrop");
    repeat (20) step();
    check_int("endrop_count", got_data.size(), 4);
    check_int("endrop_tlast", last_mask(), 'h8);
    check_int("endrop_busy", int'(busy), 0);
    check_int("endrop_fifo_left", fifo_q.size(), 4);
    check_int("endrop_bursts", int'(burst_count), 1);

    // Reset on the second beat, then a clean burst afterwards
    do_reset();
    push_seq(4, 'h80);
    enable = 1'b1;
    run_until(2, 50, 1'b0, "midrst_pre");
    reset = 1'b1;
    step();
    check_int("midrst_m_tvalid", int'(m_tvalid), 0);
    check_data("midrst_m_tdata", m_tdata, '0);
    check_int("midrst_m_tlast", int'(m_tlast), 0);
    check_int("midrst_s_tready", int'(s_tready), 0);
    check_int("midrst_busy", int'(busy), 0);
    check_int("midrst_bursts", int'(burst_count), 0);
    fifo_q.delete();
    clear_got();
    push_seq(4, 'h90);
    reset     = 1'b0;
    hold_pend = 1'b0;
    run_until(4, 60, 1'b0, "midrst_post");
    check_int("midrst_post_data", data_errs('h90), 0);
    check_int("midrst_post_tlast", last_mask(), 'h8);
    check_int("midrst_post_bursts", int'(burst_count), 1);

    // Randomized traffic against a packet-level scoreboard
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 40) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        fifo_q.push_back(d);
        sent.push_back(d);
        drive_fifo();
      end
      m_tready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 199) == 0);
      step();
    end
    m_tready = 1'b1;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    run_until(sent.size(), 2000, 1'b0, "rnd");
    repeat (2) step();
    bad = 0;
    for (int i = 0; i < got_data.size() && i < sent.size(); i++)
      if (got_data[i] !== sent[i]) bad++;
    check_int("rnd_data_order", bad, 0);
    bad = 0; len = 0; pk = 0; sh = 0;
    for (int i = 0; i < got_last.size(); i++) begin
      len++;
      if (got_last[i]) begin
        if (len > BL) bad++;
        if (len < BL) sh++;
        pk++;
        len = 0;
      end
    end
    check_int("rnd_pkt_len", bad, 0);
    check_int("rnd_trailing", len, 0);
    check_int("rnd_bursts", int'(burst_count), pk);
    check_int("rnd_short", int'(short_count), sh);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
